bitsort_pipe: RTL and testbench

//  Parametrised, pipelined bit sorter and population counter for N-bit words.
//  - Each word passes through an odd-even merge sorting network built from

---
 rtl/bitsort_pipe.sv | 138 +++++++++++++
 tb/tb_bitsort_pipe.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitsort_pipe.sv
`default_nettype none
// ============================================================================
// Module      : bitsort_pipe
// Description : Pipelined bit sorter / population counter for N-bit words.
//               Each word runs through a Batcher odd-even merge sorting
//               network of compare-exchange cells (hi = a|b, lo = a&b), so
//               the result is a thermometer code with the ones packed toward
//               the MSB. REG_EVERY network layers sit between pipeline
//               registers. The stream handshake uses a combinational ready
//               chain in which empty stages absorb bubbles.
//               Optional feature macro: BITSORT_CNT_EN builds the
//               thermometer-to-binary ones counter on out_cnt; without it
//               out_cnt is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module bitsort_pipe #(
    parameter int N         = 8,
    parameter int REG_EVERY = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_therm,
    output logic [$clog2(N+1)-1:0]   out_cnt
);

    localparam int c_LOG2N  = $clog2(N);
    localparam int c_DEPTH  = c_LOG2N * (c_LOG2N + 1) / 2;
    localparam int c_STAGES = (c_DEPTH + REG_EVERY - 1) / REG_EVERY;
    localparam int c_CW     = $clog2(N + 1);

    // Applies network layer 'lay' (numbered from the input) to word x.
    // Layers of one merge step touch disjoint wire pairs, so reading x and
    // writing y in the same pass is safe.
    function automatic logic [N-1:0] f_layer(input logic [N-1:0] x, input int lay);
        logic [N-1:0] y;
        int           idx;
        y   = x;
        idx = 0;
        for (int p = 1; p < N; p = p * 2) begin
            for (int k = p; k >= 1; k = k / 2) begin
                if (idx == lay) begin
                    for (int j = k % p; j + k < N; j = j + 2 * k) begin
                        for (int i = 0; i < k; i++) begin
                            if ((i + j + k < N) &&
                                ((i + j) / (2 * p) == (i + j + k) / (2 * p))) begin
                                y[i + j + k] = x[i + j] | x[i + j + k];
                                y[i + j]     = x[i + j] & x[i + j + k];
                            end
                        end
                    end
                end
                idx = idx + 1;
            end
        end
        return y;
    endfunction

    logic [c_STAGES-1:0]        r_v;
    logic [c_STAGES-1:0][N-1:0] r_data;
    logic [c_STAGES-1:0]        w_rdy;
    logic [c_STAGES-1:0]        w_vin;
    logic [c_STAGES-1:0][N-1:0] w_net;

    generate
        for (genvar s = 0; s < c_STAGES; s++) begin : g_stage
            logic [N-1:0] w_src;
            logic [N-1:0] w_lay;

            if (s == 0) begin : g_first
                assign w_src    = in_data;
                assign w_vin[s] = in_valid;
            end else begin : g_next
                assign w_src    = r_data[s-1];
                assign w_vin[s] = r_v[s-1];
            end

            // A stage can take new data if the sink drains or any stage from
            // here to the output is empty (the unrolled ready chain).
            assign w_rdy[s] = out_ready | ~(&r_v[c_STAGES-1:s]);

            // Apply this stage's group of layers; the last group may be short.
            always_comb begin
                w_lay = w_src;
                for (int l = 0; l < REG_EVERY; l++) begin
                    if (s * REG_EVERY + l < c_DEPTH) begin
                        w_lay = f_layer(w_lay, s * REG_EVERY + l);
                    end
                end
            end

            assign w_net[s] = w_lay;
        end
    endgenerate

    // Pipeline registers: each stage advances whenever it is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_data <= '0;
        end else begin
            for (int s = 0; s < c_STAGES; s++) begin
                if (w_rdy[s]) begin
                    r_v[s]    <= w_vin[s];
                    r_data[s] <= w_net[s];
                end
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign out_valid = r_v[c_STAGES-1];
    assign out_therm = r_v[c_STAGES-1] ? r_data[c_STAGES-1] : '0;

`ifdef BITSORT_CNT_EN
    logic [c_CW-1:0] w_cnt;

    // Thermometer to binary: the deepest set bit below the MSB gives the count.
    always_comb begin
        w_cnt = '0;
        for (int k = 1; k <= N; k++) begin
            if (out_therm[N-k]) begin
                w_cnt = c_CW'(k);
            end
        end
    end

    assign out_cnt = w_cnt;
`else
    assign out_cnt = c_CW'(0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_bitsort_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_bitsort_pipe
// Description : Self-checking bench for bitsort_pipe. Two instances
//               (N=8/REG_EVERY=1 and N=16/REG_EVERY=3) share one scoreboard
//               compare process plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bitsort_pipe;

`ifdef BITSORT_CNT_EN
    localparam bit c_CNT_ON = 1'b1;
`else
    localparam bit c_CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid8, in_ready8, out_valid8, out_ready8;
    logic [7:0]  in_data8, out_therm8;
    logic [3:0]  out_cnt8;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in_data16, out_therm16;
    logic [4:0]  out_cnt16;

    int          n_pass = 0;
    int          n_tot  = 0;
    int          n_out8 = 0;
    int          n_out16 = 0;
    logic [15:0] q8[$];
    logic [15:0] q16[$];

    always #5 clk = ~clk;

    bitsort_pipe #(.N(8), .REG_EVERY(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_therm(out_therm8), .out_cnt(out_cnt8)
    );

    bitsort_pipe #(.N(16), .REG_EVERY(3)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_data(in_data16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .out_therm(out_therm16), .out_cnt(out_cnt16)
    );

    // Model: a word with c ones sorts to c ones in the top c bit positions.
    function automatic logic [15:0] therm_of(input int n, input int c);
        logic [15:0] t;
        t = '0;
        for (int b = 0; b < c; b++) t[n-1-b] = 1'b1;
        return t;
    endfunction

    function automatic int cnt_of(input int c);
        return c_CNT_ON ? c : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: outputs checked every cycle, handshakes recorded for the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q8.delete();
            q16.delete();
        end else begin
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    n_tot++;
                    $display("FAIL spurious_out8: got therm %0h expected no output", out_therm8);
                end else begin
                    chk("sb_therm8", {8'h0, out_therm8}, therm_of(8, $countones(q8[0][7:0])));
                    chk("sb_cnt8", {28'h0, out_cnt8}, cnt_of($countones(q8[0][7:0])));
                    if (out_ready8) begin
                        void'(q8.pop_front());
                        n_out8++;
                    end
                end
            end else begin
                chk("idle_therm8", {24'h0, out_therm8}, 0);
                chk("idle_cnt8", {28'h0, out_cnt8}, 0);
            end
            if (in_valid8 && in_ready8) q8.push_back({8'h0, in_data8});

            if (out_valid16) begin
                if (q16.size() == 0) begin
                    n_tot++;
                    $display("FAIL spurious_out16: got therm %0h expected no output", out_therm16);
                end else begin
                    chk("sb_therm16", {16'h0, out_therm16}, therm_of(16, $countones(q16[0])));
                    chk("sb_cnt16", {27'h0, out_cnt16}, cnt_of($countones(q16[0])));
                    if (out_ready16) begin
                        void'(q16.pop_front());
                        n_out16++;
                    end
                end
            end else begin
                chk("idle_therm16", {16'h0, out_therm16}, 0);
                chk("idle_cnt16", {27'h0, out_cnt16}, 0);
            end
            if (in_valid16 && in_ready16) q16.push_back(in_data16);
        end
    end

    // One word into an idle pipe with the sink ready; literal latency and result.
    task automatic send_one(input bit wide, input logic [15:0] d, input logic [15:0] et,
                            input int ec, input int elat);
        int lat;
        @(posedge clk); #1;
        if (wide) begin in_valid16 = 1'b1; in_data16 = d; end
        else      begin in_valid8  = 1'b1; in_data8  = d[7:0]; end
        @(posedge clk); #1;
        in_valid8  = 1'b0;
        in_valid16 = 1'b0;
        lat = 1;
        while (!(wide ? out_valid16 : out_valid8) && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("lat", lat, elat);
        chk("therm", wide ? {16'h0, out_therm16} : {24'h0, out_therm8}, {16'h0, et});
        chk("cnt", wide ? {27'h0, out_cnt16} : {28'h0, out_cnt8}, cnt_of(ec));
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        int sent;
        int extra;
        rst_n = 1'b0;
        in_valid8 = 1'b0; in_data8 = '0; out_ready8 = 1'b1;
        in_valid16 = 1'b0; in_data16 = '0; out_ready16 = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid8, 0);
        chk("rst_therm", out_therm8, 0);
        chk("rst_cnt", out_cnt8, 0);
        chk("rst_in_ready", in_ready8, 1);

        // Single words with hand-computed results
        send_one(1'b0, 16'h0029, 16'h00E0, 3, 6);
        send_one(1'b0, 16'h0000, 16'h0000, 0, 6);
        send_one(1'b0, 16'h00FF, 16'h00FF, 8, 6);

        // Exhaustive back-to-back stream
        base = n_out8;
        for (int w = 0; w < 256; w++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1;
            in_data8  = 8'(w);
        end
        @(posedge clk); #1 in_valid8 = 1'b0;
        repeat (10) @(posedge clk);
        chk("exh_count", n_out8 - base, 256);
        chk("exh_empty", q8.size(), 0);

        // Backpressure: 10 words, sink stalled for 8 cycles from cycle 3
        base = n_out8;
        sent = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge clk); #1;
            out_ready8 = !(cyc >= 3 && cyc < 11);
            in_valid8  = (sent < 10);
            in_data8   = 8'(sent * 29 + 7);
            @(negedge clk);
            if (cyc == 8) begin
                chk("bp_in_ready", in_ready8, 0);
                chk("bp_accepted", sent, 6);
            end
            if (in_valid8 && in_ready8) sent++;
        end
        @(posedge clk); #1 in_valid8 = 1'b0; out_ready8 = 1'b1;
        repeat (3) @(posedge clk);
        chk("bp_sent", sent, 10);
        chk("bp_count", n_out8 - base, 10);

        // Bubble collapse: valid pattern 1,0,1,0,1 into a stalled pipe
        out_ready8 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid8 = (c % 2 == 0);
            in_data8  = 8'(8'h3C + c);
        end
        @(posedge clk); #1 in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("bub_out_valid", out_valid8, 1);
        chk("bub_in_ready", in_ready8, 1);
        extra = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1;
            in_data8  = 8'(8'h91 + extra * 3);
            @(negedge clk);
            if (!in_ready8) break;
            extra++;
        end
        chk("bub_extra", extra, 3);
        @(posedge clk); #1 in_valid8 = 1'b0; out_ready8 = 1'b1;
        repeat (15) @(posedge clk);
        chk("bub_drained", q8.size(), 0);

        // Reset with words in flight
        out_ready8 = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            in_valid8 = 1'b1;
            in_data8  = 8'(8'hA7 + c);
        end
        @(posedge clk); #1 in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pre_valid", out_valid8, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", out_valid8, 0);
        chk("rst_async_therm", out_therm8, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; out_ready8 = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            chk("rst_quiet", out_valid8, 0);
        end
        send_one(1'b0, 16'h0081, 16'h00C0, 2, 6);

        // Wide configuration: N=16, REG_EVERY=3
        send_one(1'b1, 16'hA5C3, 16'hFF00, 8, 4);
        send_one(1'b1, 16'hFFFF, 16'hFFFF, 16, 4);
        send_one(1'b1, 16'h0001, 16'h8000, 1, 4);
        send_one(1'b1, 16'h0000, 16'h0000, 0, 4);
        base = n_out16;
        sent = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            in_valid16  = ($urandom_range(0, 3) != 0);
            in_data16   = 16'($urandom);
            out_ready16 = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid16 && in_ready16) sent++;
        end
        @(posedge clk); #1 in_valid16 = 1'b0; out_ready16 = 1'b1;
        repeat (20) @(posedge clk);
        chk("w16_count", n_out16 - base, sent);
        chk("w16_empty", q16.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
